// File: rtl/game_winner_n.sv
// game_winner_n
// -------------
// Purpose: decides the winner of a multi-player game. Start moves the block
// from IDLE to PLAY and latches Mode. In PLAY, the game ends when Stop is
// high, or, in target mode, when any score reaches TARGET. The scores are
// then snapshotted. DECIDE visits one player per clock edge and keeps a
// running maximum and a winner mask. After the last player the result is
// registered and Done pulses for one cycle. RESULT holds the outputs until
// the next Start.
//
// Build option: define GAME_WINNER_N_TIEBREAK_EN to resolve ties to the
// lowest-index tied player (one-hot Win, Tie always 0). Without it, all
// tied players are flagged in Win and Tie is raised. Scan latency is the
// same in both builds.
//
// Ports:
//   Clk       in   clock, rising edge
//   Rst       in   synchronous active-low reset
//   Start     in   begin a new game (IDLE/RESULT only), Mode sampled with it
//   Mode      in   0 = timer mode, 1 = target mode
//   Stop      in   timer-expired / abort level (PLAY only)
//   Scores    in   packed scores, player p at [p*SCORE_W +: SCORE_W]
//   Win       out  winner mask
//   WinnerIdx out  index of lowest set Win bit
//   Tie       out  more than one Win bit set
//   Done      out  one-cycle pulse when a result becomes valid
//   Busy      out  high in PLAY and DECIDE
module game_winner_n #(
  parameter int NUM_PLAYERS = 4,
  parameter int SCORE_W     = 4,
  parameter int TARGET      = 15,
  localparam int IW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           Start,
  input  logic                           Mode,
  input  logic                           Stop,
  input  logic [NUM_PLAYERS*SCORE_W-1:0] Scores,
  output logic [NUM_PLAYERS-1:0]         Win,
  output logic [IW-1:0]                  WinnerIdx,
  output logic                           Tie,
  output logic                           Done,
  output logic                           Busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PLAY   = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  localparam logic [SCORE_W-1:0] TARGET_W = SCORE_W'(TARGET);
  localparam logic [IW-1:0]      LAST_IDX = IW'(NUM_PLAYERS - 1);

  logic [1:0]             state;
  logic                   mode_q;
  logic [IW-1:0]          scan_idx;
  logic [SCORE_W-1:0]     run_max;
  logic [NUM_PLAYERS-1:0] run_mask;
  logic [SCORE_W-1:0]     snap [NUM_PLAYERS];

  logic                   target_hit;
  logic                   trigger;
  logic [SCORE_W-1:0]     cur_score;
  logic [NUM_PLAYERS-1:0] cur_onehot;
  logic [SCORE_W-1:0]     next_max;
  logic [NUM_PLAYERS-1:0] next_mask;
  logic [IW-1:0]          final_idx;
  logic [NUM_PLAYERS-1:0] final_win;
  logic                   final_tie;

  assign Busy = (state == S_PLAY) || (state == S_DECIDE);

  // Any live score at or above the target, compared unsigned at full width.
  always_comb begin
    target_hit = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (Scores[p*SCORE_W +: SCORE_W] >= TARGET_W) begin
        target_hit = 1'b1;
      end
    end
  end

  // Stop and a target reach in the same cycle form a single OR'd trigger.
  assign trigger = Stop || (mode_q && target_hit);

  // One scan step: fold the current player into the running max and mask.
  // The first player always matches or beats the cleared max of 0, so the
  // mask is never empty once a player has been folded in.
  always_comb begin
    cur_score  = snap[scan_idx];
    cur_onehot = NUM_PLAYERS'(1) << scan_idx;
    next_max   = run_max;
    next_mask  = run_mask;
    if (cur_score > run_max) begin
      next_max  = cur_score;
      next_mask = cur_onehot;
    end else if (cur_score == run_max) begin
      next_mask = run_mask | cur_onehot;
    end
  end

  // Lowest set bit of the completed mask.
  always_comb begin
    final_idx = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (next_mask[p]) begin
        final_idx = IW'(p);
      end
    end
  end

`ifdef GAME_WINNER_N_TIEBREAK_EN
  assign final_win = NUM_PLAYERS'(1) << final_idx;
  assign final_tie = 1'b0;
`else
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign final_win = next_mask;
  assign final_tie = |(next_mask & (next_mask - NUM_PLAYERS'(1)));
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= S_IDLE;
      mode_q    <= 1'b0;
      scan_idx  <= '0;
      run_max   <= '0;
      run_mask  <= '0;
      Win       <= '0;
      WinnerIdx <= '0;
      Tie       <= 1'b0;
      Done      <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        snap[p] <= '0;
      end
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            mode_q <= Mode;
            state  <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (trigger) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              snap[p] <= Scores[p*SCORE_W +: SCORE_W];
            end
            scan_idx <= '0;
            run_max  <= '0;
            run_mask <= '0;
            state    <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          run_max  <= next_max;
          run_mask <= next_mask;
          scan_idx <= scan_idx + IW'(1);
          if (scan_idx == LAST_IDX) begin
            Win       <= final_win;
            WinnerIdx <= final_idx;
            Tie       <= final_tie;
            Done      <= 1'b1;
            scan_idx  <= '0;
            state     <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (Start) begin
            Win       <= '0;
            WinnerIdx <= '0;
            Tie       <= 1'b0;
            mode_q    <= Mode;
            state     <= S_PLAY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_winner_n.sv
// tb_game_winner_n
// ----------------
// Directed self-checking bench for game_winner_n with 4 players, 4-bit
// scores and a target of 15. Inputs are driven 1 time unit after each rising
// edge and outputs are sampled at the same point.
module tb_game_winner_n;

  localparam int NP = 4;
  localparam int SW = 4;
  localparam int IW = 2;

`ifdef GAME_WINNER_N_TIEBREAK_EN
  localparam logic [NP-1:0] TIE_777_WIN  = 4'b0001;
  localparam logic          TIE_777_TIE  = 1'b0;
  localparam logic [NP-1:0] ZERO_ALL_WIN = 4'b0001;
  localparam logic          ZERO_ALL_TIE = 1'b0;
`else
  localparam logic [NP-1:0] TIE_777_WIN  = 4'b1011;
  localparam logic          TIE_777_TIE  = 1'b1;
  localparam logic [NP-1:0] ZERO_ALL_WIN = 4'b1111;
  localparam logic          ZERO_ALL_TIE = 1'b1;
`endif

  logic              Clk = 1'b0;
  logic              Rst;
  logic              Start;
  logic              Mode;
  logic              Stop;
  logic [NP*SW-1:0]  Scores;
  logic [NP-1:0]     Win;
  logic [IW-1:0]     WinnerIdx;
  logic              Tie;
  logic              Done;
  logic              Busy;

  int assertCount = 0;
  int failCount   = 0;

  always #5 Clk = ~Clk;

  game_winner_n #(
    .NUM_PLAYERS(NP),
    .SCORE_W    (SW),
    .TARGET     (15)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .Mode     (Mode),
    .Stop     (Stop),
    .Scores   (Scores),
    .Win      (Win),
    .WinnerIdx(WinnerIdx),
    .Tie      (Tie),
    .Done     (Done),
    .Busy     (Busy)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Scores are given as p3, p2, p1, p0 nibbles.
  task automatic applyStimulus(input logic start, input logic mode,
                               input logic stop, input logic [NP*SW-1:0] scores);
    Start  = start;
    Mode   = mode;
    Stop   = stop;
    Scores = scores;
  endtask

  task automatic checkOutput(input string tag, input logic [NP-1:0] expWin,
                             input logic [IW-1:0] expIdx, input logic expTie,
                             input logic expDone, input logic expBusy);
    assertCount++;
    assert (Win === expWin) else begin
      failCount++;
      $error("FAIL %s Win: observed %b expected %b", tag, Win, expWin);
    end
    assertCount++;
    assert (WinnerIdx === expIdx) else begin
      failCount++;
      $error("FAIL %s WinnerIdx: observed %0d expected %0d", tag, WinnerIdx, expIdx);
    end
    assertCount++;
    assert (Tie === expTie) else begin
      failCount++;
      $error("FAIL %s Tie: observed %b expected %b", tag, Tie, expTie);
    end
    assertCount++;
    assert (Done === expDone) else begin
      failCount++;
      $error("FAIL %s Done: observed %b expected %b", tag, Done, expDone);
    end
    assertCount++;
    assert (Busy === expBusy) else begin
      failCount++;
      $error("FAIL %s Busy: observed %b expected %b", tag, Busy, expBusy);
    end
  endtask

  // Called right after the trigger edge: three scan edges without a result,
  // then the fourth edge must present the result with Done, then Done drops.
  task automatic runDecide(input string tag, input logic [NP-1:0] expWin,
                           input logic [IW-1:0] expIdx, input logic expTie);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput({tag, "_scan"}, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    end
    tick();
    checkOutput({tag, "_done"}, expWin, expIdx, expTie, 1'b1, 1'b0);
    tick();
    checkOutput({tag, "_hold"}, expWin, expIdx, expTie, 1'b0, 1'b0);
  endtask

  initial begin
    $display("[TB] game_winner_n directed test starting");

    // Reset state
    Rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    Rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    checkOutput("stop_in_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Timer mode, scores {3,9,2,5}; Start held during DECIDE is ignored
    applyStimulus(1'b1, 1'b0, 1'b0, {4'd5, 4'd2, 4'd9, 4'd3});
    tick();
    checkOutput("timer_play", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, {4'd5, 4'd2, 4'd9, 4'd3});
    tick();
    checkOutput("timer_wait", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, {4'd5, 4'd2, 4'd9, 4'd3});
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, {4'd5, 4'd2, 4'd9, 4'd3});
    tick();
    checkOutput("timer_scan1", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, {4'd5, 4'd2, 4'd9, 4'd3});
    tick();
    tick();
    checkOutput("timer_scan3", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("timer_done", 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("timer_hold", 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0);

    // Stop in RESULT is ignored
    applyStimulus(1'b0, 1'b0, 1'b1, {4'd5, 4'd2, 4'd9, 4'd3});
    tick();
    checkOutput("stop_in_result", 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0);

    // Target mode: p2 climbs to 15, no Stop
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    tick();
    checkOutput("target_start", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, {4'd2, 4'd14, 4'd1, 4'd3});
    tick();
    checkOutput("target_below", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, {4'd2, 4'd15, 4'd1, 4'd3});
    tick();
    runDecide("target", 4'b0100, 2'd2, 1'b0);

    // Timer mode, three-way tie {7,7,1,7}
    applyStimulus(1'b1, 1'b0, 1'b0, {4'd7, 4'd1, 4'd7, 4'd7});
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, {4'd7, 4'd1, 4'd7, 4'd7});
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, {4'd7, 4'd1, 4'd7, 4'd7});
    runDecide("tie777", TIE_777_WIN, 2'd0, TIE_777_TIE);

    // Snapshot {0,0,0,9}, live scores change to {15,0,0,0} right after
    applyStimulus(1'b1, 1'b0, 1'b0, {4'd9, 4'd0, 4'd0, 4'd0});
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, {4'd9, 4'd0, 4'd0, 4'd0});
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, {4'd0, 4'd0, 4'd0, 4'd15});
    runDecide("snapshot", 4'b1000, 2'd3, 1'b0);

    // Reset during the second DECIDE cycle aborts with no Done
    applyStimulus(1'b1, 1'b0, 1'b0, {4'd5, 4'd2, 4'd9, 4'd3});
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, {4'd5, 4'd2, 4'd9, 4'd3});
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, {4'd5, 4'd2, 4'd9, 4'd3});
    tick();
    checkOutput("abort_scan1", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    Rst = 1'b0;
    tick();
    checkOutput("abort_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    Rst = 1'b1;
    tick();
    checkOutput("abort_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("abort_idle2", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, {4'd6, 4'd0, 4'd14, 4'd1});
    tick();
    checkOutput("abort_restart", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, {4'd6, 4'd0, 4'd14, 4'd1});
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, {4'd6, 4'd0, 4'd14, 4'd1});
    runDecide("after_abort", 4'b0010, 2'd1, 1'b0);

    // All scores zero
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    runDecide("all_zero", ZERO_ALL_WIN, 2'd0, ZERO_ALL_TIE);

    // Start in RESULT clears outputs and re-enters PLAY in target mode
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    tick();
    checkOutput("restart_clear", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);

    // Stop and target reach together give a single result
    applyStimulus(1'b0, 1'b0, 1'b1, {4'd15, 4'd0, 4'd8, 4'd0});
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, {4'd15, 4'd0, 4'd8, 4'd0});
    runDecide("stop_and_target", 4'b1000, 2'd3, 1'b0);
    tick();
    checkOutput("single_done", 4'b1000, 2'd3, 1'b0, 1'b0, 1'b0);

    // Reset wins over Start on the same edge
    Rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, {4'd15, 4'd0, 4'd8, 4'd0});
    tick();
    checkOutput("reset_priority", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    Rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checkOutput("reset_priority_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/game_winner_n.md
GAME_WINNER_N -- requirements
Module: game_winner_n

Interface
REQ-001 Parameter NUM_PLAYERS, default 4, number of competing players; legal range 2..8.
REQ-002 Parameter SCORE_W, default 4, width of each player score in bits.
REQ-003 Parameter TARGET, default 15, win-by-score threshold; SHALL fit in SCORE_W bits.
REQ-004 Clk  in  1  single clock; all state changes on rising edge.
REQ-005 Rst  in  1  reset, synchronous and active-low.
REQ-006 Start  in  1  begin a new game; Mode is sampled on the same edge.
REQ-007 Mode  in  1  0 = timer mode (game ends on Stop), 1 = target mode (game ends when any score reaches TARGET, or on Stop).
REQ-008 Stop  in  1  timer-expired / abort level from the timer block.
REQ-009 Scores  in  NUM_PLAYERS*SCORE_W  packed unsigned scores, player p at bits [p*SCORE_W +: SCORE_W].
REQ-010 Win  out  NUM_PLAYERS  winner mask, one bit per player.
REQ-011 WinnerIdx  out  IW = max(1, ceil(log2(NUM_PLAYERS)))  index of the lowest-numbered set bit of Win.
REQ-012 Tie  out  1  high when more than one Win bit is set.
REQ-013 Done  out  1  one-cycle pulse when a result becomes valid.
REQ-014 Busy  out  1  high in the PLAY and DECIDE states.

Function
REQ-015 The FSM SHALL have four states: IDLE, PLAY, DECIDE and RESULT.
REQ-016 IDLE -> PLAY on Start=1; Mode SHALL be latched into an internal register on that edge.
REQ-017 In PLAY, the trigger SHALL be Stop=1, or (latched Mode=1 and any score >= TARGET).
REQ-018 On the trigger edge: Scores SHALL be snapshotted, scan index = 0, running max = 0, mask = 0, state -> DECIDE.
REQ-019 DECIDE SHALL process player k = index on each edge: snapshot[k] > max loads max and sets mask = onehot(k); snapshot[k] == max ORs onehot(k) into mask; index increments.
REQ-020 After player NUM_PLAYERS-1 is processed, state -> RESULT; on that same edge Win, WinnerIdx and Tie SHALL be registered and Done SHALL go high for exactly one cycle.
REQ-021 Latency from the trigger-sampling edge to Done high SHALL be exactly NUM_PLAYERS edges.
REQ-022 Scores changing during DECIDE SHALL NOT affect the result (snapshot only).
REQ-023 If all scores are equal (including all zero), Win SHALL be all ones, Tie = 1 and WinnerIdx = 0.
REQ-024 RESULT holds the outputs; Start=1 SHALL clear Win, WinnerIdx, Tie, latch the new Mode and go to PLAY.
REQ-025 Start SHALL be ignored in PLAY and DECIDE; Stop SHALL be ignored in IDLE, DECIDE and RESULT.
REQ-026 A Stop and a target reach in the same cycle SHALL give one trigger, not two.
REQ-027 Comparisons SHALL be unsigned at full SCORE_W width, with no wrap or saturation.

Reset
REQ-028 Rst=0 at any edge, in any state (including mid-DECIDE), SHALL force IDLE and clear Win=0, WinnerIdx=0, Tie=0, Done=0, Busy=0, the latched Mode, the scan index, the max and the mask.
REQ-029 Rst SHALL take priority over Start and Stop on the same edge.

Configuration
REQ-030 The macro GAME_WINNER_N_TIEBREAK_EN controls tie handling.
- Defined: ties SHALL resolve to the lowest-index tied player; Win is one-hot and Tie stays 0.
- Not defined: REQ-012 and REQ-023 apply (multi-hot Win, Tie=1).
- Scan latency SHALL be identical in both builds.

Verification (NUM_PLAYERS=4, SCORE_W=4, TARGET=15)
REQ-031 Timer mode, scores {3,9,2,5} for p0..p3, Stop pulse -> Done 4 edges later, Win=4'b0010, WinnerIdx=1, Tie=0.
REQ-032 Target mode, p2 reaches 15 while others <15, no Stop -> Win=4'b0100, WinnerIdx=2, Done once.
REQ-033 Timer mode, scores {7,7,1,7}, Stop -> without the macro: Win=4'b1011, Tie=1, WinnerIdx=0; with GAME_WINNER_N_TIEBREAK_EN: Win=4'b0001, Tie=0.
REQ-034 Scores changed to {15,0,0,0} on the cycle after the trigger, snapshot was {0,0,0,9} -> Win=4'b1000.
REQ-035 Rst=0 during the 2nd DECIDE cycle -> next cycle IDLE, all outputs 0, no Done; Start then runs a normal game.
REQ-036 All scores 0, Stop -> Win=4'b1111, Tie=1; Start in RESULT then clears outputs and asserts Busy.
